// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter.
// Grants one of NUM_MASTERS masters the shared address/control path, re-arbitrating
// only at legal burst boundaries (or on the second ERROR cycle). Locked sequences
// keep the bus. hgrant, hmaster and hmastlock are all registered, so there is no
// combinational path from any input to any output.
module ahb_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int MW          = $clog2(NUM_MASTERS)
) (
    input  logic                   hclk,
    input  logic                   hrst_n,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic                   hready,
    input  logic                   hresp,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [MW-1:0]          hmaster,
    output logic                   hmastlock
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    localparam logic [2:0] BURST_SINGLE = 3'b000;
    localparam logic [2:0] BURST_INCR   = 3'b001;

    logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
    logic [MW-1:0]          hmaster_q, hmaster_d;
    logic                   hmastlock_q, hmastlock_d;
    logic [4:0]             beats_left_q, beats_left_d;

    logic [MW-1:0] owner;
    logic          locked;
    logic [4:0]    burst_last;
    logic          at_boundary;
    logic          arb_ok;
    logic [MW-1:0] scan_idx;
    logic [MW-1:0] next_owner;
    logic          found;

    // Encode the one-hot grant into the index of the current bus owner.
    always_comb begin
        owner = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (hgrant_q[i]) begin
                owner = owner | MW'(i);
            end
        end
        locked = hlock[owner];
    end

    // Number of beats remaining after a NONSEQ, i.e. burst length minus one.
    always_comb begin
        case (hburst)
            3'b010, 3'b011: burst_last = 5'd3;
            3'b100, 3'b101: burst_last = 5'd7;
            3'b110, 3'b111: burst_last = 5'd15;
            default:        burst_last = 5'd0;   // SINGLE and undefined-length INCR
        endcase
    end

    // Track beats of the burst in flight; only accepted transfers (hready=1) count.
    always_comb begin
        beats_left_d = beats_left_q;
        if (hready) begin
            if (hresp || htrans == TRANS_IDLE) begin
                beats_left_d = 5'd0;
            end else if (htrans == TRANS_NONSEQ) begin
                beats_left_d = burst_last;
            end else if (htrans == TRANS_SEQ && beats_left_q != 5'd0) begin
                beats_left_d = beats_left_q - 5'd1;
            end
        end
    end

    // Decide whether this edge is a legal point to hand the bus over.
    always_comb begin
        at_boundary = (htrans == TRANS_IDLE)
                   || hresp
                   || (htrans == TRANS_NONSEQ && hburst == BURST_SINGLE)
                   || (htrans == TRANS_SEQ && beats_left_q == 5'd1)
                   || (hburst == BURST_INCR
                       && (htrans == TRANS_NONSEQ || htrans == TRANS_SEQ)
                       && !hbusreq[owner]);
        arb_ok = hready && !locked && (htrans != TRANS_BUSY) && at_boundary;
    end

    // Round-robin scan starting after the owner; the owner itself is checked last.
    // With no requester at all next_owner stays 0, which selects the default master.
    always_comb begin
        next_owner = '0;
        scan_idx   = '0;
        found      = 1'b0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            scan_idx = MW'((int'(owner) + k) % NUM_MASTERS);
            if (!found && hbusreq[scan_idx]) begin
                found      = 1'b1;
                next_owner = scan_idx;
            end
        end
    end

    // Next grant and address-phase ownership; everything freezes during wait states.
    always_comb begin
        hgrant_d = hgrant_q;
        if (arb_ok) begin
            hgrant_d             = '0;
            hgrant_d[next_owner] = 1'b1;
        end
        hmaster_d   = hready ? owner  : hmaster_q;
        hmastlock_d = hready ? locked : hmastlock_q;
    end

    // State registers; reset drops everything back to the default master.
    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            hgrant_q     <= NUM_MASTERS'(1);
            hmaster_q    <= '0;
            hmastlock_q  <= 1'b0;
            beats_left_q <= 5'd0;
        end else begin
            hgrant_q     <= hgrant_d;
            hmaster_q    <= hmaster_d;
            hmastlock_q  <= hmastlock_d;
            beats_left_q <= beats_left_d;
        end
    end

    assign hgrant    = hgrant_q;
    assign hmaster   = hmaster_q;
    assign hmastlock = hmastlock_q;

endmodule
